// File: rtl/enc_scan_if.sv
// enc_scan_if: request-vector input and index-stream output bundle for enc_scan.
// The master side supplies vectors and consumes indices; the slave side is the encoder.
interface enc_scan_if #(
    parameter int unsigned N = 3
);
    localparam int unsigned W  = 1 << N;
    localparam int unsigned CW = N + 1;

    logic [W-1:0]  in_vec;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  out_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          done;
    logic [CW-1:0] count;

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_idx, out_valid, out_last, done, count
    );

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_idx, out_valid, out_last, done, count
    );
endinterface

// File: rtl/enc_scan.sv
// enc_scan: sequential priority encoder. It takes a 2**N-bit multi-hot vector and
// streams the index of every set bit, one per output handshake. The default order is
// lowest index first. Defining ENC_SCAN_MSB_FIRST_EN streams the highest index first.
module enc_scan #(
    parameter int unsigned N = 3
) (
    input  logic        clk,
    input  logic        rst,
    enc_scan_if.slave   bus
);
    localparam int unsigned W  = 1 << N;
    localparam int unsigned CW = N + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [W-1:0]  pending_q;
    logic [CW-1:0] count_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          done_q;

    logic [N-1:0]  idx_c;
    logic          onehot_c;
    logic          last_c;
    logic [W-1:0]  pending_d;
    logic [CW-1:0] count_d;

    // Priority-encode the bit to present next from the pending register.
    always_comb begin
        idx_c = '0;
`ifdef ENC_SCAN_MSB_FIRST_EN
        for (int i = 0; i < int'(W); i++) begin
            if (pending_q[i]) idx_c = N'(i);
        end
`else
        for (int i = int'(W) - 1; i >= 0; i--) begin
            if (pending_q[i]) idx_c = N'(i);
        end
`endif
    end

    // Last-beat detection and the pending vector with the presented bit removed.
    always_comb begin
        onehot_c  = (pending_q != '0) && ((pending_q & (pending_q - W'(1))) == '0);
        last_c    = out_valid_q & onehot_c;
        pending_d = pending_q & ~(W'(1) << idx_c);
    end

    // Population count of the incoming vector, captured on acceptance.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(W); i++) begin
            count_d = count_d + CW'(bus.in_vec[i]);
        end
    end

    // Control FSM: accept in IDLE, one beat per handshake in SCAN, single done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        pending_q  <= bus.in_vec;
                        count_q    <= count_d;
                        in_ready_q <= 1'b0;
                        if (bus.in_vec != '0) begin
                            state_q     <= SCAN;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (bus.out_ready) begin
                        pending_q <= pending_d;
                        if (last_c) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = idx_c;
    assign bus.out_last  = last_c;
    assign bus.done      = done_q;
    assign bus.count     = count_q;
endmodule
